// File: rtl/mpmc10_req_fifo128_fta.sv
// ---------------------------------------------------------------------------
// mpmc10_req_fifo128_fta
//
// Elastic command buffer on the MPMC10 port path.
//
// It queues up to DEPTH 128-bit FTA command requests from a client port. The
// oldest queued entry is presented on a registered output, first-word-fall-
// through style. That output feeds the request sync register stage.
//
// Ports
//   clk      in   system clock, all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   i        in   client request (i.cyc=1 marks a valid command)
//   full_o   out  registered, 1 when count_o==DEPTH
//   o        out  registered oldest entry (o.cyc=1 marks valid), else zero
//   rdy_i    in   downstream accept; a pop happens when o.cyc && rdy_i
//   count_o  out  registered number of held entries, including the one on o
//   ovf_o    out  sticky: a push was attempted while full
// ---------------------------------------------------------------------------
package fta_pkg;
  // 128-bit FTA command request: 1+1+14+16+32+64 = 128 bits.
  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [13:0] tid;
    logic [15:0] sel;
    logic [31:0] adr;
    logic [63:0] dat;
  } fta_cmd_request128_t;
endpackage

module mpmc10_req_fifo128_fta
  import fta_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  fta_cmd_request128_t i,
  output logic                full_o,
  output fta_cmd_request128_t o,
  input  logic                rdy_i,
  output logic [AW:0]         count_o,
  output logic                ovf_o
);

  // Storage holds every queued entry, including the one mirrored on o.
  fta_cmd_request128_t mem_q [DEPTH];

  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  fta_cmd_request128_t o_q, o_d;

  logic                push;
  logic                pop;
  logic [AW:0]         remain;
  logic                bypass;

  always_comb begin
    push     = i.cyc && !full_q;
    pop      = o_q.cyc && rdy_i;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The entry left after the pop. If nothing is left and a push lands this
    // edge, the new head is the request now being written. It is not yet
    // readable from mem_q, so take it straight from i.
    remain = count_q - (AW+1)'(pop);
    bypass = push && (remain == '0);

    o_d = '0;
    if (count_d != '0) begin
      o_d = bypass ? i : mem_q[rd_ptr_d];
    end

    full_d = (count_d == (AW+1)'(DEPTH));
    // A request presented while full is dropped but remembered forever.
    ovf_d  = ovf_q | (i.cyc & full_q);
  end

  // Storage write path carries no reset: its contents are don't-care until
  // written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      o_q      <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      o_q      <= o_d;
    end
  end

  assign o       = o_q;
  assign full_o  = full_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_mpmc10_req_fifo128_fta.sv
// ---------------------------------------------------------------------------
// Testbench for mpmc10_req_fifo128_fta.
//
// A queue-based reference model tracks what the FIFO must hold. A compare
// process checks every DUT output against that model on each falling clock
// edge. Directed scenarios add hand-computed literal expectations that pin
// the model.
// ---------------------------------------------------------------------------
module tb_mpmc10_req_fifo128_fta;
  import fta_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic                clk;
  logic                rst_n;
  fta_cmd_request128_t i;
  logic                full_o;
  fta_cmd_request128_t o;
  logic                rdy_i;
  logic [AW:0]         count_o;
  logic                ovf_o;

  int n_cmp;
  int n_bad;

  mpmc10_req_fifo128_fta #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .full_o  (full_o),
    .o       (o),
    .rdy_i   (rdy_i),
    .count_o (count_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ----------------------------------------------------------------------
  // Reference model: a plain queue of accepted requests plus a sticky flag.
  // ----------------------------------------------------------------------
  fta_cmd_request128_t mq[$];
  logic                m_ovf;
  logic                m_push;
  logic                m_pop;

  initial m_ovf = 1'b0;

  always @(negedge rst_n) begin
    mq.delete();
    m_ovf = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      // The full flag seen by the client is the occupancy before this edge.
      m_push = i.cyc && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && rdy_i;
      if (i.cyc && mq.size() == DEPTH) m_ovf = 1'b1;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(i);
    end
  end

  // Compare process: checks the DUT against the model on every cycle.
  fta_cmd_request128_t exp_o;
  logic [AW:0]         exp_cnt;
  always @(negedge clk) begin
    exp_o   = (mq.size() > 0) ? mq[0] : '0;
    exp_cnt = (AW+1)'(mq.size());
    n_cmp++;
    if (o !== exp_o) begin
      n_bad++;
      $display("FAIL model_o t=%0t got=%h want=%h", $time, o, exp_o);
    end
    n_cmp++;
    if (count_o !== exp_cnt) begin
      n_bad++;
      $display("FAIL model_count t=%0t got=%0d want=%0d", $time, count_o, exp_cnt);
    end
    n_cmp++;
    if (full_o !== (mq.size() == DEPTH)) begin
      n_bad++;
      $display("FAIL model_full t=%0t got=%b want=%b", $time, full_o, (mq.size() == DEPTH));
    end
    n_cmp++;
    if (ovf_o !== m_ovf) begin
      n_bad++;
      $display("FAIL model_ovf t=%0t got=%b want=%b", $time, ovf_o, m_ovf);
    end
  end

  // ----------------------------------------------------------------------
  // Helpers
  // ----------------------------------------------------------------------
  function automatic fta_cmd_request128_t mk(input logic [31:0] adr);
    fta_cmd_request128_t r;
    r     = '0;
    r.cyc = 1'b1;
    r.we  = adr[0];
    r.tid = adr[13:0] ^ 14'h2a5;
    r.sel = ~adr[15:0];
    r.adr = adr;
    r.dat = {adr ^ 32'hdead_beef, ~adr};
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ----------------------------------------------------------------------
  // Directed stimulus
  // ----------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rdy_i = 1'b0;
    i     = mk(32'habc);

    // Reset held with a valid request presented: nothing may enter.
    repeat (3) tick();
    check("rst_o",     128'(o), 128'h0);
    check("rst_count", 128'(count_o), 128'h0);
    check("rst_full",  128'(full_o), 128'h0);
    check("rst_ovf",   128'(ovf_o), 128'h0);

    rst_n = 1'b1;
    i     = '0;
    tick();
    check("idle_cyc", 128'(o.cyc), 128'h0);

    // Single pass: push at one edge, visible after it, popped at the next.
    i     = mk(32'h100);
    rdy_i = 1'b1;
    tick();
    i = '0;
    check("single_cyc", 128'(o.cyc), 128'h1);
    check("single_adr", 128'(o.adr), 128'h100);
    tick();
    check("single_gone", 128'(o.cyc), 128'h0);
    check("single_cnt",  128'(count_o), 128'h0);

    // Fill with downstream stalled.
    rdy_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      i = mk(32'(k * 16));
      tick();
    end
    i = '0;
    check("fill_full", 128'(full_o), 128'h1);
    check("fill_cnt",  128'(count_o), 128'h4);
    check("fill_adr",  128'(o.adr), 128'h10);

    // Overflow: push while full is dropped and flagged.
    i = mk(32'h50);
    tick();
    i = '0;
    check("ovf_flag", 128'(ovf_o), 128'h1);
    check("ovf_cnt",  128'(count_o), 128'h4);

    // Drain: consecutive cycles, no bubble, 0x50 never appears.
    rdy_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_adr%0d", k), 128'(o.adr), 128'(k * 16));
      tick();
    end
    check("drain_empty", 128'(o.cyc), 128'h0);
    check("drain_ovf",   128'(ovf_o), 128'h1);

    // Streaming through the wrap: o follows one cycle behind.
    for (int k = 0; k < 10; k++) begin
      i = mk(32'(k));
      tick();
      check($sformatf("stream_adr%0d", k), 128'(o.adr), 128'(k));
      check($sformatf("stream_cnt%0d", k), 128'(count_o <= 1), 128'h1);
    end
    i = '0;
    tick();
    check("stream_end", 128'(o.cyc), 128'h0);

    // Reset mid-stream with three entries queued.
    rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i = mk(32'h200 + 32'(k));
      tick();
    end
    i = '0;
    check("pre_rst_cnt", 128'(count_o), 128'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cyc", 128'(o.cyc), 128'h0);
    check("async_cnt", 128'(count_o), 128'h0);
    tick();
    rst_n = 1'b1;
    i     = mk(32'h77);
    tick();
    i = '0;
    check("post_rst_adr", 128'(o.adr), 128'h77);
    check("post_rst_cnt", 128'(count_o), 128'h1);
    check("post_rst_o",   128'(o), 128'(mk(32'h77)));

    // Mixed push/pop pattern, checked by the model each cycle.
    for (int k = 0; k < 24; k++) begin
      i     = ((k % 3) != 2) ? mk(32'h300 + 32'(k)) : '0;
      rdy_i = ((k % 4) == 1) || ((k % 4) == 2);
      tick();
    end
    i     = '0;
    rdy_i = 1'b1;
    repeat (6) tick();
    check("final_empty", 128'(count_o), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
